// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus stable-time filter FSM for a bouncy contact input.
// Optional saturating glitch statistics are built when DEBOUNCE_GLITCH_CNT_EN is defined.
module input_debouncer #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_in,
  output logic       signal_out,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [7:0] glitch_count
);

  localparam int TW = $clog2(STABLE_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] ONE  = TW'(1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          sync1, sync2;
  logic          sig_nxt, rise_nxt, fall_nxt;

  // raw_in is asynchronous; only sync2 may be looked at by the filter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= STABLE_LOW;
      timer      <= '0;
      signal_out <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      signal_out <= sig_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    sig_nxt   = signal_out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (sync2) begin
          state_nxt = WAIT_HIGH;
          timer_nxt = ONE;
        end else begin
          timer_nxt = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2) begin
          state_nxt = STABLE_LOW;
          timer_nxt = '0;
        end else if (timer == LAST) begin
          state_nxt = STABLE_HIGH;
          timer_nxt = '0;
          sig_nxt   = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          timer_nxt = timer + ONE;
        end
      end
      STABLE_HIGH: begin
        if (!sync2) begin
          state_nxt = WAIT_LOW;
          timer_nxt = ONE;
        end else begin
          timer_nxt = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2) begin
          state_nxt = STABLE_HIGH;
          timer_nxt = '0;
        end else if (timer == LAST) begin
          state_nxt = STABLE_LOW;
          timer_nxt = '0;
          sig_nxt   = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          timer_nxt = timer + ONE;
        end
      end
      default: begin
        state_nxt = STABLE_LOW;
        timer_nxt = '0;
        sig_nxt   = 1'b0;
      end
    endcase
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  // a glitch is a wait abandoned by the input returning to the committed level
  logic glitch_evt;
  assign glitch_evt = ((state == WAIT_HIGH) && !sync2) || ((state == WAIT_LOW) && sync2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      glitch_count <= 8'd0;
    else if (glitch_evt && (glitch_count != 8'hFF))
      glitch_count <= glitch_count + 8'd1;
  end
`else
  assign glitch_count = 8'd0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with STABLE_CYCLES=4; glitch expectations
// follow whether DEBOUNCE_GLITCH_CNT_EN is defined for the build.
module tb_input_debouncer;

  localparam int SC = 4;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  localparam int GEN = 1;
`else
  localparam int GEN = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       raw_in;
  logic       signal_out, rise_pulse, fall_pulse;
  logic [7:0] glitch_count;

  int tests = 0;
  int fails = 0;

  input_debouncer #(.STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .reset       (reset),
    .raw_in      (raw_in),
    .signal_out  (signal_out),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic s, input logic r, input logic f);
    chk({tag, ".signal_out"}, {7'd0, signal_out}, {7'd0, s});
    chk({tag, ".rise_pulse"}, {7'd0, rise_pulse}, {7'd0, r});
    chk({tag, ".fall_pulse"}, {7'd0, fall_pulse}, {7'd0, f});
  endtask

  function automatic logic [7:0] gexp(input int n);
    return (GEN != 0) ? 8'(n) : 8'd0;
  endfunction

  initial begin
    reset  = 1'b1;
    raw_in = 1'b0;
    step(2);
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.glitch", glitch_count, 8'd0);
    reset = 1'b0;

    // idle low for 50 cycles
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk_out("idle", 1'b0, 1'b0, 1'b0);
      chk("idle.glitch", glitch_count, 8'd0);
    end

    // clean rise: first high sample at edge k, commit after edge k+1+SC
    raw_in = 1'b1;
    step(SC + 1);
    chk_out("rise.pre", 1'b0, 1'b0, 1'b0);
    step(1);
    chk_out("rise.commit", 1'b1, 1'b1, 1'b0);
    step(1);
    chk_out("rise.after", 1'b1, 1'b0, 1'b0);
    step(3);
    chk_out("rise.hold", 1'b1, 1'b0, 1'b0);

    // clean fall, symmetric
    raw_in = 1'b0;
    step(SC + 1);
    chk_out("fall.pre", 1'b1, 1'b0, 1'b0);
    step(1);
    chk_out("fall.commit", 1'b0, 1'b0, 1'b1);
    step(1);
    chk_out("fall.after", 1'b0, 1'b0, 1'b0);
    step(3);

    // bounce: high 3, low 1, high 3, low 1, then steady high
    raw_in = 1'b1;
    for (int i = 0; i < 3; i++) begin step(1); chk_out("bounce.a", 1'b0, 1'b0, 1'b0); end
    raw_in = 1'b0;
    step(1);
    chk_out("bounce.b", 1'b0, 1'b0, 1'b0);
    raw_in = 1'b1;
    for (int i = 0; i < 3; i++) begin step(1); chk_out("bounce.c", 1'b0, 1'b0, 1'b0); end
    raw_in = 1'b0;
    step(1);
    chk_out("bounce.d", 1'b0, 1'b0, 1'b0);
    raw_in = 1'b1;
    step(SC + 1);
    chk_out("bounce.pre", 1'b0, 1'b0, 1'b0);
    step(1);
    chk_out("bounce.commit", 1'b1, 1'b1, 1'b0);
    chk("bounce.glitch", glitch_count, gexp(2));

    raw_in = 1'b0;
    step(SC + 4);
    chk_out("bounce.fall", 1'b0, 1'b0, 1'b0);

    // exactly SC-cycle pulse is accepted, then falls SC+1 later
    raw_in = 1'b1;
    step(SC);
    raw_in = 1'b0;
    step(1);
    chk_out("p4.pre", 1'b0, 1'b0, 1'b0);
    step(1);
    chk_out("p4.rise", 1'b1, 1'b1, 1'b0);
    step(SC - 1);
    chk_out("p4.hold", 1'b1, 1'b0, 1'b0);
    step(1);
    chk_out("p4.fall", 1'b0, 1'b0, 1'b1);
    chk("p4.glitch", glitch_count, gexp(2));
    step(3);

    // SC-1 cycle pulse is rejected
    raw_in = 1'b1;
    step(SC - 1);
    raw_in = 1'b0;
    for (int i = 0; i < 8; i++) begin step(1); chk_out("p3", 1'b0, 1'b0, 1'b0); end
    chk("p3.glitch", glitch_count, gexp(3));

    // async reset during WAIT_HIGH with timer at 2, raw_in held high
    raw_in = 1'b1;
    step(SC);
    #2 reset = 1'b1;
    #1;
    chk_out("rst.async", 1'b0, 1'b0, 1'b0);
    chk("rst.glitch", glitch_count, 8'd0);
    step(3);
    chk_out("rst.held", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(SC + 1);
    chk_out("rst.pre", 1'b0, 1'b0, 1'b0);
    step(1);
    chk_out("rst.rise", 1'b1, 1'b1, 1'b0);
    chk("rst.glitch2", glitch_count, 8'd0);

    raw_in = 1'b0;
    step(SC + 4);
    chk_out("sat.start", 1'b0, 1'b0, 1'b0);

    // 300 single-cycle glitches saturate the counter at 255
    for (int i = 0; i < 300; i++) begin
      raw_in = 1'b1;
      step(1);
      raw_in = 1'b0;
      step(1);
      chk("sat.sig", {7'd0, signal_out}, 8'd0);
    end
    step(4);
    chk_out("sat.end", 1'b0, 1'b0, 1'b0);
    chk("sat.glitch", glitch_count, gexp(255));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
